// File: rtl/gmux_qen_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | gmux_qen_ctrl_pkg : quadrant indices, FSM encoding, settle default |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package gmux_qen_ctrl_pkg;

  localparam int c_tl = 0;
  localparam int c_tr = 1;
  localparam int c_bl = 2;
  localparam int c_br = 3;

  localparam int c_settle_default = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OFF = 2'd1,
    ST_WAIT_ON  = 2'd2
  } state_e;

  // A quadrant cannot be enabled while it sits in its low-power state.
  function automatic logic [3:0] legal_sen(input logic [3:0] sen, input logic [3:0] vlp);
    return sen & ~vlp;
  endfunction

  function automatic logic all_set(input logic [3:0] v);
    return v[c_tl] & v[c_tr] & v[c_bl] & v[c_br];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gmux_qen_ctrl_if.sv
// +------------------------------------------------------------------+
// | gmux_qen_ctrl_if : configuration request handshake               |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface gmux_qen_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_ssel;
  logic [3:0] cfg_sen;
  logic [3:0] cfg_dynen;
  logic [3:0] cfg_vlp;

  modport master (
    output cfg_valid, cfg_ssel, cfg_sen, cfg_dynen, cfg_vlp,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ssel, cfg_sen, cfg_dynen, cfg_vlp,
    output cfg_ready
  );
endinterface

`default_nettype wire

// File: rtl/gmux_settle_cnt.sv
// +------------------------------------------------------------------+
// | gmux_settle_cnt : loadable settle down-counter, saturates at 1   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gmux_settle_cnt (
  input  wire logic       clk,
  input  wire logic       resetn,
  input  wire logic       load,
  input  wire logic [7:0] load_val,
  input  wire logic       dec,
  output logic            last
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count > 8'd1)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign last = (r_count == 8'd1);

endmodule

`default_nettype wire

// File: rtl/gmux_qen_ctrl.sv
// +------------------------------------------------------------------+
// | gmux_qen_ctrl : sequences clock-mux quadrant gating changes      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gmux_qen_ctrl
  import gmux_qen_ctrl_pkg::*;
#(
  parameter int SETTLE = c_settle_default
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  gmux_qen_ctrl_if.slave  cfg,
  input  wire logic [3:0] gate,
  output logic            ssel,
  output logic [3:0]      sen,
  output logic [3:0]      den,
  output logic [3:0]      dynen,
  output logic [3:0]      vlp,
  output logic            active,
  output logic            done,
  output logic            err
);

  localparam logic [7:0] c_settle = 8'(SETTLE);

  state_e     r_state;
  state_e     w_next;
  logic       r_ready;
  logic       w_accept;
  logic       w_off_done;
  logic       w_on_done;
  logic       w_last;

  logic       r_lat_ssel;
  logic [3:0] r_lat_sen;
  logic [3:0] r_lat_dynen;
  logic [3:0] r_lat_vlp;

  logic       r_ssel;
  logic [3:0] r_sen;
  logic [3:0] r_den;
  logic [3:0] r_dynen;
  logic [3:0] r_vlp;
  logic       r_done;
  logic       r_err;

  gmux_settle_cnt u_settle_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (w_accept | w_off_done),
    .load_val (c_settle),
    .dec      (r_state != ST_IDLE),
    .last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_off_done = 1'b0;
    w_on_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg.cfg_valid && r_ready) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT_OFF;
        end
      end
      ST_WAIT_OFF: begin
        if (w_last) begin
          w_off_done = 1'b1;
          w_next     = ST_WAIT_ON;
        end
      end
      ST_WAIT_ON: begin
        if (w_last) begin
          w_on_done = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Gating sequence: drop anything that changes, switch modes, then re-enable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lat_ssel  <= 1'b0;
      r_lat_sen   <= 4'd0;
      r_lat_dynen <= 4'd0;
      r_lat_vlp   <= 4'd0;
      r_ssel      <= 1'b0;
      r_sen       <= 4'd0;
      r_dynen     <= 4'd0;
      r_vlp       <= 4'hF;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_on_done;
      if (w_accept) begin
        r_lat_ssel  <= cfg.cfg_ssel;
        r_lat_sen   <= cfg.cfg_sen;
        r_lat_dynen <= cfg.cfg_dynen;
        r_lat_vlp   <= cfg.cfg_vlp;
        r_sen       <= r_sen & cfg.cfg_sen & ~(r_vlp ^ cfg.cfg_vlp) & ~(r_dynen ^ cfg.cfg_dynen);
        r_err       <= r_err | (|(cfg.cfg_sen & cfg.cfg_vlp));
      end
      if (w_off_done) begin
        r_ssel  <= r_lat_ssel;
        r_vlp   <= r_lat_vlp;
        r_dynen <= r_lat_dynen;
      end
      if (w_on_done) begin
        r_sen <= legal_sen(r_lat_sen, r_lat_vlp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_den <= 4'd0;
    end else begin
      r_den <= r_dynen & r_sen & gate;
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign ssel          = r_ssel;
  assign sen           = r_sen;
  assign den           = r_den;
  assign dynen         = r_dynen;
  assign vlp           = r_vlp;
  assign done          = r_done;
  assign err           = r_err;
  assign active        = r_ssel & all_set(r_sen) & ~(|r_den) & ~(|r_vlp);

endmodule

`default_nettype wire

// File: tb/tb_gmux_qen_ctrl.sv
// +------------------------------------------------------------------+
// | tb_gmux_qen_ctrl : directed scoreboard bench for gmux_qen_ctrl   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gmux_qen_ctrl;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] gate = 4'd0;
  logic       ssel;
  logic [3:0] sen;
  logic [3:0] den;
  logic [3:0] dynen;
  logic [3:0] vlp;
  logic       active;
  logic       done;
  logic       err;

  gmux_qen_ctrl_if cfg_if ();

  gmux_qen_ctrl #(.SETTLE(S)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cfg    (cfg_if),
    .gate   (gate),
    .ssel   (ssel),
    .sen    (sen),
    .den    (den),
    .dynen  (dynen),
    .vlp    (vlp),
    .active (active),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_at;
    logic       ssel;
    logic [3:0] sen;
    logic [3:0] dyn;
    logic [3:0] vlp;
    logic       act;
    logic       err;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every DONE pulse retires the oldest expected reconfiguration.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.done_at);
        chk("done_ssel", ssel, e.ssel);
        chk("done_sen", sen, e.sen);
        chk("done_dynen", dynen, e.dyn);
        chk("done_vlp", vlp, e.vlp);
        chk("done_active", active, e.act);
        chk("done_err", err, e.err);
        chk("done_ready", cfg_if.cfg_ready, 1);
      end
    end
  end

  // Called at a negedge; returns the accept edge number k.
  task automatic issue(input logic s, input logic [3:0] se, input logic [3:0] dy,
                       input logic [3:0] vl, input logic [3:0] e_sen, input logic e_act,
                       input logic e_err, input bit push, input bit hold, output int k);
    int n;
    exp_t e;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ssel  = s;
    cfg_if.cfg_sen   = se;
    cfg_if.cfg_dynen = dy;
    cfg_if.cfg_vlp   = vl;
    n = 0;
    while (cfg_if.cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", cfg_if.cfg_ready, 1);
    k = cyc + 1;
    if (push) begin
      e.done_at = k + 2 * S;
      e.ssel = s; e.sen = e_sen; e.dyn = dy; e.vlp = vl; e.act = e_act; e.err = e_err;
      q.push_back(e);
    end
    @(negedge clk);
    if (!hold) cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ssel"}, ssel, 0);
    chk({tag, "_sen"}, sen, 0);
    chk({tag, "_den"}, den, 0);
    chk({tag, "_dynen"}, dynen, 0);
    chk({tag, "_vlp"}, vlp, 4'hF);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ready"}, cfg_if.cfg_ready, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int k2;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ssel  = 1'b0;
    cfg_if.cfg_sen   = 4'd0;
    cfg_if.cfg_dynen = 4'd0;
    cfg_if.cfg_vlp   = 4'd0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cfg_if.cfg_ready, 1);

    // Bring the mux to full pass-through.
    issue(1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, k);
    chk("t1_sen_k", sen, 0);
    chk("t1_ready_k", cfg_if.cfg_ready, 0);
    wait_to(k + 3);
    chk("t1_vlp_k3", vlp, 4'hF);
    wait_to(k + 4);
    chk("t1_vlp_k4", vlp, 4'h0);
    chk("t1_ssel_k4", ssel, 1);
    chk("t1_sen_k4", sen, 0);
    wait_to(k + 7);
    chk("t1_done_k7", done, 0);
    wait_to(k + 8);
    chk("t1_active_k8", active, 1);
    wait_to(k + 9);
    chk("t1_done_k9", done, 0);

    // Put TL into low power.
    issue(1'b1, 4'hE, 4'h0, 4'h1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, k);
    chk("t2_sen_k", sen, 4'hE);
    wait_to(k + 3);
    chk("t2_vlp_k3", vlp, 4'h0);
    wait_to(k + 4);
    chk("t2_vlp_k4", vlp, 4'h1);
    wait_to(k + 8);
    chk("t2_sen_k8", sen, 4'hE);
    chk("t2_active_k8", active, 0);

    // Illegal: TL enabled while in low power.
    issue(1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, k);
    chk("t3_err_k", err, 1);
    chk("t3_sen_k", sen, 0);
    wait_to(k + 9);
    chk("t3_sen_k9", sen, 0);

    // All quadrants dynamic; then drive gate requests.
    issue(1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, k);
    wait_to(k + 8);
    gate = 4'b0101;
    wait_to(k + 9);
    chk("t4_den_gate", den, 4'b0101);
    chk("t4_active_gate", active, 0);
    chk("t4_err_sticky", err, 1);
    gate = 4'b0000;
    wait_to(k + 10);
    chk("t4_den_clear", den, 0);
    chk("t4_active_clear", active, 1);

    // Reset in the middle of a sequence.
    issue(1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, k);
    wait_to(k + 2);
    resetn = 1'b0;
    wait_to(k + 3);
    chk_reset_vals("midrst");
    resetn = 1'b1;
    wait_to(k + 4);
    chk("midrst_ready_release", cfg_if.cfg_ready, 1);
    chk("midrst_no_done", done, 0);

    // Held request with changing fields mid-sequence.
    issue(1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, k);
    issue(1'b0, 4'h3, 4'h0, 4'h0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, k2);
    chk("t6_next_accept", k2, k + 9);
    chk("t6_sen_k2", sen, 4'h3);
    wait_to(k2 + 10);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gmux_qen_ctrl.md
GMUX_QEN_CTRL -- requirements
Module: gmux_qen_ctrl

Interface
REQ-001 Parameter SETTLE, default 4, means cycles waited after each gating step; legal range 1..255.
REQ-002 Quadrant bit order for every 4-bit bus SHALL be [0]=TL, [1]=TR, [2]=BL, [3]=BR.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RESETN  in  1  synchronous, active-low reset.
REQ-005 CFG_VALID  in  1  new configuration offered; held until accepted.
REQ-006 CFG_READY  out  1  controller idle; configuration accepted when CFG_VALID&CFG_READY at an edge.
REQ-007 CFG_SSEL  in  1  requested source select.
REQ-008 CFG_SEN  in  4  requested static enables.
REQ-009 CFG_DYNEN  in  4  requested dynamic-gating mode per quadrant.
REQ-010 CFG_VLP  in  4  requested low-power state per quadrant.
REQ-011 GATE  in  4  runtime dynamic gate request per quadrant.
REQ-012 SSEL  out  1; SEN, DEN, DYNEN, VLP  out  4 each; all drive the matching pins of the downstream global high-speed clock mux.
REQ-013 ACTIVE  out  1  high when the mux is in full pass-through configuration.
REQ-014 DONE  out  1  one-cycle pulse when a reconfiguration completes.
REQ-015 ERR  out  1  sticky flag: illegal request seen.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_OFF, WAIT_ON; CFG_READY=1 only in IDLE.
REQ-017 On accept at edge k: latch CFG_*; SEN <= SEN & CFG_SEN & ~(VLP ^ CFG_VLP) & ~(DYNEN ^ CFG_DYNEN); counter <= SETTLE; state -> WAIT_OFF.
REQ-018 Counter SHALL decrement by 1 each cycle in WAIT_OFF/WAIT_ON; it is 8 bits wide and never wraps below 1.
REQ-019 In WAIT_OFF, at the edge where counter==1 (edge k+SETTLE): SSEL, VLP, DYNEN <= latched values; counter <= SETTLE; state -> WAIT_ON.
REQ-020 In WAIT_ON, at the edge where counter==1 (edge k+2*SETTLE): SEN <= latched CFG_SEN & ~latched CFG_VLP; DONE=1 for one cycle; state -> IDLE.
REQ-021 A quadrant requested with CFG_SEN=1 and CFG_VLP=1 is illegal: its SEN is held 0 and ERR is set at the accept edge; the other quadrants proceed normally.
REQ-022 A request identical to the current state SHALL still run the full 2*SETTLE sequence with no output glitch.
REQ-023 CFG_VALID while CFG_READY=0 SHALL be ignored; the latched configuration is not altered mid-sequence.
REQ-024 DEN[q] SHALL be registered each cycle as DYNEN[q] & SEN[q] & GATE[q], giving 1-cycle latency; DEN is 0 whenever SEN or DYNEN is 0.
REQ-025 ACTIVE = SSEL & (all SEN=1) & (all DEN=0) & (all VLP=0), decoded from registered outputs only.
REQ-026 No output SHALL toggle more than once per reconfiguration.

Reset
REQ-027 While RESETN=0 at an edge: state=IDLE, counter=0, SSEL=0, SEN=0, DEN=0, DYNEN=0, VLP=4'b1111, DONE=0, ERR=0, CFG_READY=0.
REQ-028 CFG_READY SHALL rise at the first edge after RESETN returns to 1.
REQ-029 Reset asserted mid-sequence SHALL abort the sequence, apply the REQ-027 values, and produce no DONE pulse.

Structure
REQ-030 The quadrant index constants (TL=0, TR=1, BL=2, BR=3), the FSM state encoding and the SETTLE default SHALL live in a shared gmux package.
REQ-031 One sub-module, gmux_settle_cnt (load/decrement/last flag), is natural; all other logic stays flat.

Verification
REQ-032 Reset release, then accept SSEL=1, SEN=F, DYNEN=0, VLP=0 at edge k with SETTLE=4 -> VLP=0 and SSEL=1 at k+4; SEN=F, ACTIVE=1 and DONE pulse at k+8.
REQ-033 From the active state, request SEN=4'b1110, VLP=4'b0001 -> SEN[0] falls at k, VLP[0] rises at k+4, SEN stays 4'b1110 at k+8, ACTIVE=0.
REQ-034 Request SEN=4'b0001 with VLP=4'b0001 -> ERR=1 at k; SEN=0 after k+8; ERR stays 1 until reset.
REQ-035 With DYNEN=F and SEN=F, drive GATE=4'b0101 -> DEN=4'b0101 one cycle later and ACTIVE=0; GATE=0 -> DEN=0 and ACTIVE=1 one cycle later.
REQ-036 Pulse RESETN=0 at k+3 mid-sequence -> outputs take the REQ-027 values, no DONE pulse, CFG_READY=1 one edge after release.
REQ-037 Hold CFG_VALID with changing CFG_* during a sequence -> only the accept-edge values are applied; the next accept occurs at k+9.
